// File: rtl/watch_adv_if.sv
// -----------------------------------------------------------------------------
// watch_adv_if -- button/mode inputs and display outputs of the watch_adv block.
//
// Signals (directions as seen by the watch core, modport slave):
//   btn_left, btn_right, btn_up, btn_down  in   single-cycle debounced pulses
//   i_edit                                 in   1 = halt counting, edit enabled
//   i_blink_disable                        in   forces o_pos_sel to 0
//   i_mode_12h                             in   12-hour display format
//   i_alarm_sel                            in   edit/display the alarm (if built in)
//   o_pos_sel [2:0]                        out  one-hot cursor (sec, min, hour)
//   o_msec [6:0], o_sec [5:0], o_min [5:0] out  displayed fields
//   o_hour [4:0], o_pm, o_alarm            out  displayed hour, PM flag, alarm flag
//
// Modport master is the driving side (buttons/modes out, display in).
// -----------------------------------------------------------------------------
interface watch_adv_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       i_edit;
    logic       i_blink_disable;
    logic       i_mode_12h;
    logic       i_alarm_sel;
    logic [2:0] o_pos_sel;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_pm;
    logic       o_alarm;

    modport master (
        output btn_left, btn_right, btn_up, btn_down,
        output i_edit, i_blink_disable, i_mode_12h, i_alarm_sel,
        input  o_pos_sel, o_msec, o_sec, o_min, o_hour, o_pm, o_alarm
    );

    modport slave (
        input  btn_left, btn_right, btn_up, btn_down,
        input  i_edit, i_blink_disable, i_mode_12h, i_alarm_sel,
        output o_pos_sel, o_msec, o_sec, o_min, o_hour, o_pm, o_alarm
    );
endinterface

// File: rtl/watch_adv.sv
// -----------------------------------------------------------------------------
// watch_adv -- stopwatch-style time-of-day counter with cursor-based editing.
//
// A prescaler divides clk by CLK_HZ/TICK_HZ; each tick advances the
// msec:sec:min:hour chain (24-hour internal form). While i_edit=1 counting is
// halted and the buttons move the cursor (left/right) and step the selected
// field (up/down, wrap within the field, no carry).
//
// Parameters:
//   CLK_HZ   input clock frequency in Hz
//   TICK_HZ  msec-field rate; CLK_HZ/TICK_HZ must be an integer >= 2 and
//            TICK_HZ <= 128 (msec field is 7 bits)
//
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  watch_adv_if.slave -- buttons, mode inputs and display outputs
//
// Optional feature, macro WATCH_ADV_ALARM_EN: adds alarm_hour/alarm_min
// registers (reset 07:00), alarm editing/display via i_alarm_sel and the
// o_alarm flag. Without it i_alarm_sel is ignored and o_alarm is 0.
// -----------------------------------------------------------------------------
module watch_adv #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic         clk,
    input  logic         rst,
    watch_adv_if.slave   bus
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [6:0]    MSEC_MAX  = 7'(TICK_HZ - 1);

    // Cursor positions
    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;

    // Step a 0..max_v field by one, wrapping in both directions.
    function automatic logic [5:0] step6(input logic [5:0] v, input logic [5:0] max_v,
                                         input logic inc);
        if (inc) begin
            return (v == max_v) ? 6'd0 : v + 6'd1;
        end
        return (v == 6'd0) ? max_v : v - 6'd1;
    endfunction

    function automatic logic [4:0] step_hour(input logic [4:0] v, input logic inc);
        if (inc) begin
            return (v == 5'd23) ? 5'd0 : v + 5'd1;
        end
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    msec_q, msec_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [1:0]    pos_q, pos_d;

    logic tick;
    logic inc, dec;
    logic any_btn;

    assign tick    = !bus.i_edit && (presc_q == PRESC_MAX);
    assign inc     = bus.btn_up && !bus.btn_down;
    assign dec     = bus.btn_down && !bus.btn_up;
    assign any_btn = bus.btn_left | bus.btn_right | bus.btn_up | bus.btn_down;

`ifdef WATCH_ADV_ALARM_EN
    logic [4:0] alarm_hour_q, alarm_hour_d;
    logic [5:0] alarm_min_q, alarm_min_d;
    logic       alarm_q, alarm_d;
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = bus.i_alarm_sel ^ any_btn;
`endif

    // -------------------------------------------------------------------------
    // Next-state: prescaler, time chain, cursor, alarm registers
    // -------------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        msec_d  = msec_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        pos_d   = pos_q;
`ifdef WATCH_ADV_ALARM_EN
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
`endif

        // Prescaler is parked at 0 during edit so the first tick after
        // leaving edit lands exactly DIV cycles later.
        if (bus.i_edit) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (tick) begin
            if (msec_q == MSEC_MAX) begin
                msec_d = 7'd0;
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d  = 6'd0;
                        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                msec_d = msec_q + 7'd1;
            end
        end else if (bus.i_edit) begin
            // Cursor: left moves toward hour, right toward sec, both wrap.
            if (bus.btn_left && !bus.btn_right) begin
                pos_d = (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
            end else if (bus.btn_right && !bus.btn_left) begin
                pos_d = (pos_q == POS_SEC) ? POS_HOUR : pos_q - 2'd1;
            end

            if (inc || dec) begin
`ifdef WATCH_ADV_ALARM_EN
                if (bus.i_alarm_sel) begin
                    // Alarm has no seconds; POS_SEC is inert here.
                    case (pos_q)
                        POS_MIN:  alarm_min_d  = step6(alarm_min_q, 6'd59, inc);
                        POS_HOUR: alarm_hour_d = step_hour(alarm_hour_q, inc);
                        default:  ;
                    endcase
                end else
`endif
                begin
                    case (pos_q)
                        POS_SEC: begin
                            sec_d  = step6(sec_q, 6'd59, inc);
                            msec_d = 7'd0;
                        end
                        POS_MIN:  min_d  = step6(min_q, 6'd59, inc);
                        POS_HOUR: hour_d = step_hour(hour_q, inc);
                        default:  ;
                    endcase
                end
            end
        end
    end

`ifdef WATCH_ADV_ALARM_EN
    logic alarm_match;

    // Only a running carry that lands on hh:mm:00.00 fires the alarm.
    assign alarm_match = tick && (msec_d == 7'd0) && (sec_d == 6'd0) &&
                         (min_d == alarm_min_q) && (hour_d == alarm_hour_q);

    always_comb begin
        alarm_d = alarm_q;
        if (any_btn || bus.i_edit) begin
            alarm_d = 1'b0;
        end else if (alarm_match) begin
            alarm_d = 1'b1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            msec_q  <= 7'd0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 5'd0;
            pos_q   <= POS_SEC;
        end else begin
            presc_q <= presc_d;
            msec_q  <= msec_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            pos_q   <= pos_d;
        end
    end

`ifdef WATCH_ADV_ALARM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hour_q <= 5'd7;
            alarm_min_q  <= 6'd0;
            alarm_q      <= 1'b0;
        end else begin
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            alarm_q      <= alarm_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Display
    // -------------------------------------------------------------------------
    logic       show_alarm;
    logic [4:0] src_hour;
    logic [5:0] src_min;
    logic [5:0] src_sec;
    logic [6:0] src_msec;

`ifdef WATCH_ADV_ALARM_EN
    assign show_alarm = bus.i_edit && bus.i_alarm_sel;
`else
    assign show_alarm = 1'b0;
`endif

    always_comb begin
        src_hour = hour_q;
        src_min  = min_q;
        src_sec  = sec_q;
        src_msec = msec_q;
`ifdef WATCH_ADV_ALARM_EN
        if (show_alarm) begin
            src_hour = alarm_hour_q;
            src_min  = alarm_min_q;
            src_sec  = 6'd0;
            src_msec = 7'd0;
        end
`endif
    end

    always_comb begin
        bus.o_hour = src_hour;
        if (bus.i_mode_12h) begin
            if (src_hour == 5'd0) begin
                bus.o_hour = 5'd12;
            end else if (src_hour > 5'd12) begin
                bus.o_hour = src_hour - 5'd12;
            end
        end
    end

    always_comb begin
        bus.o_pos_sel = 3'b000;
        if (bus.i_edit && !bus.i_blink_disable) begin
            case (pos_q)
                POS_SEC:  bus.o_pos_sel = 3'b001;
                POS_MIN:  bus.o_pos_sel = 3'b010;
                POS_HOUR: bus.o_pos_sel = 3'b100;
                default:  bus.o_pos_sel = 3'b000;
            endcase
        end
    end

    assign bus.o_msec = src_msec;
    assign bus.o_sec  = src_sec;
    assign bus.o_min  = src_min;
    assign bus.o_pm   = (src_hour >= 5'd12);

`ifdef WATCH_ADV_ALARM_EN
    assign bus.o_alarm = alarm_q;
`else
    assign bus.o_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_watch_adv.sv
// -----------------------------------------------------------------------------
// tb_watch_adv -- directed bench for watch_adv (CLK_HZ=1000, TICK_HZ=100).
// Stimulus pushes hand-computed expected values into a scoreboard queue; a
// monitor on the falling clock edge pops and compares each entry against the
// current display outputs.
// -----------------------------------------------------------------------------
module tb_watch_adv;

    typedef enum int {KMsec, KSec, KMin, KHour, KPm, KPos, KAlarm} kind_e;

    typedef struct {
        string name;
        kind_e kind;
        int    exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    chk_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    watch_adv_if bus ();

    watch_adv #(
        .CLK_HZ  (1000),
        .TICK_HZ (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int actual_of(kind_e k);
        case (k)
            KMsec:   return int'(bus.o_msec);
            KSec:    return int'(bus.o_sec);
            KMin:    return int'(bus.o_min);
            KHour:   return int'(bus.o_hour);
            KPm:     return int'(bus.o_pm);
            KPos:    return int'(bus.o_pos_sel);
            default: return int'(bus.o_alarm);
        endcase
    endfunction

    // Monitor: drain every pending expectation at the falling edge.
    always @(negedge clk) begin
        chk_t c;
        int   act;
        while (sb_q.size() > 0) begin
            c   = sb_q.pop_front();
            act = actual_of(c.kind);
            n_total++;
            if (act == c.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: actual=%0d required=%0d", c.name, act, c.exp);
            end
        end
    end

    task automatic want(input string name, input kind_e k, input int v);
        chk_t c;
        c.name = name;
        c.kind = k;
        c.exp  = v;
        sb_q.push_back(c);
    endtask

    task automatic want_time(input string tag, input int h, input int m, input int s,
                             input int ms);
        want({tag, ".hour"}, KHour, h);
        want({tag, ".min"},  KMin,  m);
        want({tag, ".sec"},  KSec,  s);
        want({tag, ".msec"}, KMsec, ms);
    endtask

    // Let the monitor consume what has been queued.
    task automatic chk();
        @(negedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic l, input logic r, input logic u, input logic d);
        bus.btn_left  = l;
        bus.btn_right = r;
        bus.btn_up    = u;
        bus.btn_down  = d;
        cyc(1);
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
    endtask

    initial begin
        bus.btn_left        = 1'b0;
        bus.btn_right       = 1'b0;
        bus.btn_up          = 1'b0;
        bus.btn_down        = 1'b0;
        bus.i_edit          = 1'b0;
        bus.i_blink_disable = 1'b0;
        bus.i_mode_12h      = 1'b0;
        bus.i_alarm_sel     = 1'b0;

        // Reset state, held in reset while the mode inputs are varied.
        cyc(3);
        want_time("rst", 0, 0, 0, 0);
        want("rst.pm", KPm, 0);
        want("rst.pos", KPos, 0);
        want("rst.alarm", KAlarm, 0);
        chk();
        bus.i_mode_12h = 1'b1;
        want("rst.hour12", KHour, 12);
        want("rst.pm12", KPm, 0);
        chk();
        bus.i_mode_12h = 1'b0;
        bus.i_edit     = 1'b1;
        want("rst.pos_edit", KPos, 1);
        chk();
        bus.i_edit = 1'b0;
        rst        = 1'b0;

        // First tick after exactly 10 cycles, then one second.
        cyc(9);
        want("run.msec_pre", KMsec, 0);
        chk();
        cyc(1);
        want("run.msec_1", KMsec, 1);
        chk();
        cyc(990);
        want("run.sec_1", KSec, 1);
        want("run.msec_0", KMsec, 0);
        chk();

        // Edit: cursor moves, field wraps, simultaneous buttons.
        bus.i_edit = 1'b1;
        want("edit.pos0", KPos, 3'b001);
        chk();
        press(0, 1, 0, 0);
        want("edit.right_wrap", KPos, 3'b100);
        chk();
        press(0, 0, 0, 1);
        want("edit.hour_down_wrap", KHour, 23);
        press(1, 0, 0, 0);
        want("edit.left_wrap", KPos, 3'b001);
        chk();
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        want("edit.sec_down_wrap", KSec, 59);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        want("edit.min_down_wrap", KMin, 59);
        want("edit.pos_min", KPos, 3'b010);
        chk();
        press(0, 0, 1, 0);
        want("edit.min_up_wrap", KMin, 0);
        chk();
        press(0, 0, 0, 1);
        press(0, 0, 1, 1);
        want("edit.updown_same", KMin, 59);
        press(1, 1, 0, 0);
        want("edit.leftright_same", KPos, 3'b010);
        want("edit.hour_kept", KHour, 23);
        chk();
        bus.i_blink_disable = 1'b1;
        want("edit.blink_off", KPos, 0);
        chk();
        bus.i_blink_disable = 1'b0;
        bus.i_mode_12h      = 1'b1;
        want("edit.hour23_12h", KHour, 11);
        want("edit.pm23_12h", KPm, 1);
        chk();
        bus.i_mode_12h = 1'b0;

        // Resume from 23:59:59.00 and roll over midnight.
        bus.i_edit = 1'b0;
        cyc(9);
        want("resume.msec_pre", KMsec, 0);
        chk();
        cyc(1);
        want("resume.msec_1", KMsec, 1);
        chk();
        cyc(980);
        want_time("pre_wrap", 23, 59, 59, 99);
        want("pre_wrap.pm", KPm, 1);
        chk();
        cyc(10);
        want_time("wrap", 0, 0, 0, 0);
        want("wrap.pm", KPm, 0);
        chk();
        bus.i_mode_12h = 1'b1;
        want("wrap.hour12", KHour, 12);
        chk();
        bus.i_mode_12h = 1'b0;

        // Buttons ignored while running (well inside one tick period).
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        press(1, 1, 1, 1);
        want_time("run_btn", 0, 0, 0, 0);
        chk();
        bus.i_edit = 1'b1;
        want("run_btn.pos_kept", KPos, 3'b010);
        chk();

        // Editing sec clears msec.
        bus.i_edit = 1'b0;
        cyc(30);
        bus.i_edit = 1'b1;
        want("msec_clr.pre", KMsec, 3);
        chk();
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        want("msec_clr.sec", KSec, 1);
        want("msec_clr.msec", KMsec, 0);
        want("msec_clr.pos", KPos, 3'b001);
        chk();

        // Hour 13 in both formats.
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        repeat (13) press(0, 0, 1, 0);
        bus.i_edit     = 1'b0;
        bus.i_mode_12h = 1'b1;
        want("h13.hour12", KHour, 1);
        want("h13.pm12", KPm, 1);
        chk();
        bus.i_mode_12h = 1'b0;
        want("h13.hour24", KHour, 13);
        want("h13.pm24", KPm, 1);
        chk();

        // Reset mid-edit overrides a simultaneous button.
        bus.i_edit = 1'b1;
        rst        = 1'b1;
        press(0, 0, 1, 0);
        rst = 1'b0;
        want_time("rst_edit", 0, 0, 0, 0);
        want("rst_edit.pos", KPos, 3'b001);
        want("rst_edit.alarm", KAlarm, 0);
        chk();

`ifdef WATCH_ADV_ALARM_EN
        bus.i_alarm_sel = 1'b1;
        want_time("alm_rst", 7, 0, 0, 0);
        want("alm_rst.pm", KPm, 0);
        chk();
        bus.i_mode_12h = 1'b1;
        want("alm_rst.hour12", KHour, 7);
        chk();
        bus.i_mode_12h = 1'b0;
        press(0, 1, 0, 0);
        repeat (7) press(0, 0, 0, 1);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        want_time("alm_set", 0, 1, 0, 0);
        chk();
        bus.i_alarm_sel = 1'b0;
        want_time("alm_time_kept", 0, 0, 0, 0);
        chk();
        press(0, 0, 0, 1);
        bus.i_edit = 1'b0;
        cyc(990);
        want_time("alm_pre", 0, 0, 59, 99);
        want("alm_pre.alarm", KAlarm, 0);
        chk();
        cyc(10);
        want_time("alm_hit", 0, 1, 0, 0);
        want("alm_hit.alarm", KAlarm, 1);
        chk();
        press(0, 0, 1, 0);
        want("alm_clr.alarm", KAlarm, 0);
        want("alm_clr.min", KMin, 1);
        chk();
`else
        bus.i_alarm_sel = 1'b1;
        want("noalm.hour", KHour, 0);
        chk();
        press(0, 0, 0, 1);
        want("noalm.sec_edit", KSec, 59);
        chk();
        bus.i_alarm_sel = 1'b0;
        bus.i_edit      = 1'b0;
        cyc(1000);
        want_time("noalm.run", 0, 1, 0, 0);
        want("noalm.alarm", KAlarm, 0);
        chk();
`endif

        chk();
        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/watch_adv.md
WATCH_ADV -- requirements
Module: watch_adv

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, msec-field count rate; CLK_HZ/TICK_HZ SHALL be an integer >= 2 and TICK_HZ SHALL be <= 128.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_left, btn_right, btn_up, btn_down  input  1 each  single-cycle, already-debounced button pulses.
REQ-006 i_edit  input  1  1 = counting halted and edit enabled; 0 = run.
REQ-007 i_blink_disable  input  1  forces o_pos_sel to 0.
REQ-008 i_mode_12h  input  1  selects the 12-hour display format.
REQ-009 i_alarm_sel  input  1  when 1 during edit, edits and displays the alarm instead of the time.
REQ-010 o_pos_sel  output  3  one-hot cursor: bit0 sec, bit1 min, bit2 hour.
REQ-011 o_msec  output  7; o_sec  output  6; o_min  output  6; o_hour  output  5  displayed fields.
REQ-012 o_pm  output  1; o_alarm  output  1.

Function
REQ-013 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 while i_edit=0, emitting a one-cycle tick at the terminal count; it SHALL be held at 0 while i_edit=1.
REQ-014 On tick, msec SHALL increment; msec wraps TICK_HZ-1->0 and carries to sec; sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0; all carries resolve in the same cycle.
REQ-015 Cursor pos (0 sec, 1 min, 2 hour) SHALL change only while i_edit=1: btn_left pos+1 (2->0), btn_right pos-1 (0->2); both asserted in the same cycle: no change.
REQ-016 In edit, btn_up SHALL increment the selected field modulo its range (sec/min 60, hour 24) and btn_down decrement it (0->max); no carry into neighbouring fields; both asserted in the same cycle: no change.
REQ-017 Any up/down edit of sec SHALL also clear msec to 0.
REQ-018 All four buttons SHALL be ignored while i_edit=0.
REQ-019 o_pos_sel SHALL be 0 when i_blink_disable=1 or i_edit=0, otherwise one-hot of pos; combinational from registered state.
REQ-020 Time is held internally in 24-hour form; with i_mode_12h=1 o_hour SHALL show 0->12, 13..23->h-12, 1..12 unchanged.
REQ-021 o_pm SHALL be 1 when the displayed source hour >= 12, in both formats.
REQ-022 Deasserting i_edit SHALL resume counting from the edited value; first tick after exactly CLK_HZ/TICK_HZ cycles.

Reset
REQ-023 On rst=1 at a clock edge: prescaler, msec, sec, min, hour = 0; pos = 0; o_alarm = 0; alarm = 07:00; rst SHALL override every button and mode input, including mid-edit.
REQ-024 Reset state outputs: o_msec/o_sec/o_min = 0, o_hour = 0 (24h) or 12 (12h), o_pm = 0, o_pos_sel = 0 unless i_edit=1 and i_blink_disable=0 (then 3'b001).

Configuration
REQ-025 Macro WATCH_ADV_ALARM_EN: when defined, the block SHALL contain alarm_hour (5b) and alarm_min (6b) registers.
REQ-026 With the macro, edit with i_alarm_sel=1 routes up/down to alarm_min (pos 1) or alarm_hour (pos 2); pos 0 ignores up/down; time fields remain unchanged.
REQ-027 With the macro, edit with i_alarm_sel=1 SHALL display o_hour/o_min = alarm values, o_sec = o_msec = 0, with o_pm and the 12h format applied.
REQ-028 With the macro, o_alarm SHALL be set the cycle after a running carry brings the time to alarm_hour:alarm_min:00.00, and cleared by any button pulse or i_edit=1; set and clear in the same cycle: clear wins.
REQ-029 Without the macro, there SHALL be no alarm registers, i_alarm_sel is ignored and o_alarm is constant 0.

Verification (CLK_HZ=1000, TICK_HZ=100, divide 10)
REQ-030 Reset, run 10 cycles -> o_msec=1 on cycle 11; 1000 cycles -> o_sec=1, o_msec=0.
REQ-031 Preload 23:59:59.99 via edit, run one tick -> 00:00:00.00, o_pm=0; 12h mode o_hour=12.
REQ-032 Edit pos 0, btn_right -> o_pos_sel=3'b100; btn_down at hour 0 -> hour 23; up+down together -> unchanged; i_blink_disable=1 -> o_pos_sel=0.
REQ-033 i_edit=0, pulse every button -> time, pos unchanged; hour 13, i_mode_12h=1 -> o_hour=1, o_pm=1.
REQ-034 Macro defined: set alarm 00:01, time 00:00:59.99, run one tick -> o_alarm=1 next cycle; btn_up pulse -> o_alarm=0; macro undefined -> o_alarm stays 0.
